// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared fetch constants, PC alignment helper and fetch FSM states.
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_wait_counter
// Purpose  : Saturating imem wait counter with clear and sticky timeout fault.
// Revision : 1.0
// ============================================================================
module fetch_wait_counter #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_fault
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] c_limit = CW'(WAIT_LIMIT);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_fault;

    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_inc && (r_count != c_limit)) begin
            w_count_next = r_count + CW'(1);
        end
    end

    // Fault rises in the same cycle the count first reads WAIT_LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_fault <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_count_next == c_limit) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_fault = r_fault;

endmodule : fetch_wait_counter
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: owns the PC, reads imem, hands {pc,inst}
//            to decode and handles redirects including in-flight squash.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_inst;
    logic         r_inst_valid;
    logic         r_imem_req;
    logic         r_kill;

    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_pc_next;
    logic         w_wait_inc;
    logic         w_wait_clr;

    assign w_redirect_pc = align_pc(redirect_pc);
    assign w_pc_next     = align_pc(pc_next);

    // A raised request can't be withdrawn, so imem_addr comes from its own
    // latch and stays on the stale address while a squash is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b0;
            r_kill       <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                        if (redirect) begin
                            r_pc       <= w_redirect_pc;
                            r_req_addr <= w_redirect_pc;
                        end else begin
                            r_req_addr <= r_pc;
                        end
                    end else if (imem_ack) begin
                        r_imem_req <= 1'b0;
                        if (redirect) begin
                            r_pc <= w_redirect_pc;
                        end else begin
                            r_inst       <= imem_rdata;
                            r_inst_valid <= 1'b1;
                            r_state      <= ST_HOLD;
                        end
                    end else if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_kill  <= 1'b1;
                        r_state <= ST_KILL;
                    end
                end

                ST_HOLD: begin
                    if (redirect) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_redirect_pc;
                        r_req_addr   <= w_redirect_pc;
                        r_imem_req   <= 1'b1;
                        r_state      <= ST_FETCH;
                    end else if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_pc_next;
                        r_req_addr   <= w_pc_next;
                        r_imem_req   <= 1'b1;
                        r_state      <= ST_FETCH;
                    end
                end

                ST_KILL: begin
                    if (redirect) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (imem_ack && r_kill) begin
                        r_kill     <= 1'b0;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_FETCH;
                    end
                end

                default: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b0;
                    r_kill     <= 1'b0;
                end
            endcase
        end
    end

    assign w_wait_inc = r_imem_req & ~imem_ack;
    assign w_wait_clr = r_imem_req & imem_ack;

    fetch_wait_counter #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_wait_inc),
        .i_clr   (w_wait_clr),
        .o_fault (fault)
    );

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_req_addr;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int WL = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_latency = 0;
    bit          mem_hold    = 1'b0;
    bit          stray_ack   = 1'b0;
    bit          use_fixed   = 1'b0;
    logic [31:0] fixed_npc   = 32'h0;
    int          wait_cnt    = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .WAIT_LIMIT (WL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fault       (fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1234};
    endfunction

    // Memory image and update_pc stand-in; they act just after the test
    // stimulus so they see this cycle's controls.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        pc_next    = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            pc_next = use_fixed ? fixed_npc : pc + 32'd4;
            if (stray_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req && !mem_hold && wait_cnt >= mem_latency) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                if (imem_req) wait_cnt++;
                else wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        mem_hold    = 1'b0;
        stray_ack   = 1'b0;
        use_fixed   = 1'b0;
        mem_latency = 0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_req_at(input logic [31:0] a, input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound && !ok; n++) begin
            tick();
            if (imem_req && imem_addr == a) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound && !ok; n++) begin
            tick();
            if (inst_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        repeat (2) tick();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc); end
        n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault); end
        reset = 1'b0;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] exp_pc   = 32'h0;
        int          last     = -1;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (imem_req) begin
                n_checks++;
                if (imem_addr !== exp_addr) begin
                    n_fail++; $display("FAIL zw_addr: got %h want %h", imem_addr, exp_addr);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != 2) begin
                        n_fail++; $display("FAIL zw_spacing: got %0d cycles want 2", c - last);
                    end
                end
                last = c;
                exp_addr += 32'd4;
            end
            if (inst_valid) begin
                n_checks++;
                if (pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL zw_inst: got pc=%h inst=%h want pc=%h inst=%h", pc, inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
            end
        end
        n_checks++;
        if (exp_pc !== 32'h1C) begin
            n_fail++; $display("FAIL zw_count: got next pc %h want 1c", exp_pc);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_stall();
        int          n = 0;
        logic [31:0] hp;
        logic [31:0] hi;
        do_reset();
        mem_latency = 3;
        tick();
        while (imem_req && !inst_valid && n < 20) begin
            n_checks++;
            if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL st_addr_stable: got %h want 0", imem_addr); end
            n++;
            tick();
        end
        n_checks++;
        if (n != 4 || inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL st_latency: got %0d req cycles valid=%b want 4 valid=1", n, inst_valid);
        end
        hp = pc; hi = inst;
        n_checks++;
        if (hi !== mem_word(32'h0)) begin n_fail++; $display("FAIL st_inst: got %h want %h", hi, mem_word(32'h0)); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (inst_valid !== 1'b1 || pc !== hp || inst !== hi || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL st_hold: got valid=%b pc=%h inst=%h req=%b want 1 %h %h 0", inst_valid, pc, inst, imem_req, hp, hi);
            end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_fail++; $display("FAIL st_accept: got valid=%b req=%b addr=%h want 0 1 4", inst_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_kill();
        bit ok;
        bit seen_req = 1'b0;
        bit seen_val = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        wait_req_at(32'h10, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rk_reach: got timeout want req at 10"); end
        mem_hold = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc !== 32'h100 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rk_kill: got req=%b addr=%h pc=%h valid=%b want 1 10 100 0", imem_req, imem_addr, pc, inst_valid);
        end
        tick();
        mem_hold = 1'b0;
        for (int k = 0; k < 20 && !seen_val; k++) begin
            tick();
            if (imem_req && !seen_req) begin
                seen_req = 1'b1;
                n_checks++;
                if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rk_next_req: got %h want 100", imem_addr); end
            end
            if (inst_valid) begin
                seen_val = 1'b1;
                n_checks++;
                if (pc !== 32'h100 || inst !== mem_word(32'h100)) begin
                    n_fail++; $display("FAIL rk_first_valid: got pc=%h inst=%h want 100 %h", pc, inst, mem_word(32'h100));
                end
            end
        end
        n_checks++;
        if (!seen_val) begin n_fail++; $display("FAIL rk_timeout: got no valid want valid at 100"); end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        do_reset();
        wait_valid(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rh_reach: got timeout want valid"); end
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        use_fixed = 1'b1; fixed_npc = 32'h40;
        tick();
        redirect = 1'b0; use_fixed = 1'b0; inst_ready = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || pc !== 32'h80 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            n_fail++; $display("FAIL rh_target: got valid=%b pc=%h req=%b addr=%h want 0 80 1 80", inst_valid, pc, imem_req, imem_addr);
        end
        tick();
        n_checks++;
        if (inst_valid !== 1'b1 || inst !== mem_word(32'h80)) begin
            n_fail++; $display("FAIL rh_inst: got valid=%b inst=%h want 1 %h", inst_valid, inst, mem_word(32'h80));
        end
    endtask

    task automatic test_fault();
        bit ok;
        do_reset();
        mem_hold = 1'b1;
        tick();
        for (int k = 0; k <= WL + 3; k++) begin
            if (k == WL - 1) begin
                n_checks++;
                if (fault !== 1'b0) begin n_fail++; $display("FAIL ft_early: got %b want 0 at %0d", fault, k); end
            end
            if (k == WL) begin
                n_checks++;
                if (fault !== 1'b1) begin n_fail++; $display("FAIL ft_limit: got %b want 1 at %0d", fault, k); end
            end
            tick();
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL ft_still_waiting: got req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        mem_hold = 1'b0;
        wait_valid(10, ok);
        n_checks++;
        if (!ok || inst !== mem_word(32'h0) || fault !== 1'b1) begin
            n_fail++; $display("FAIL ft_complete: got ok=%b inst=%h fault=%b want 1 %h 1", ok, inst, fault, mem_word(32'h0));
        end
        inst_ready = 1'b1;
        repeat (4) tick();
        inst_ready = 1'b0;
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL ft_sticky: got %b want 1", fault); end
        do_reset();
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL ft_cleared: got %b want 0", fault); end
    endtask

    task automatic test_reset_in_kill();
        bit ok;
        do_reset();
        inst_ready = 1'b1;
        wait_req_at(32'h8, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rkl_reach: got timeout want req at 8"); end
        mem_hold = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++; $display("FAIL rkl_kill: got req=%b addr=%h want 1 8", imem_req, imem_addr);
        end
        reset = 1'b1; mem_hold = 1'b0;
        tick();
        n_checks++;
        if (pc !== 32'h0 || inst !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL rkl_reset: got pc=%h inst=%h valid=%b req=%b fault=%b want 0 0 0 0 0", pc, inst, inst_valid, imem_req, fault);
        end
        reset = 1'b0; stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rkl_restart: got req=%b addr=%h valid=%b want 1 0 0", imem_req, imem_addr, inst_valid);
        end
        wait_valid(10, ok);
        n_checks++;
        if (!ok || pc !== 32'h0 || inst !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL rkl_first: got ok=%b pc=%h inst=%h want 1 0 %h", ok, pc, inst, mem_word(32'h0));
        end
        inst_ready = 1'b0;
    endtask

    // Reference: the stream of delivered instructions must follow program
    // order (pc+4 on accept, target on redirect) with inst = memory[pc].
    task automatic test_random();
        logic [31:0] exp_pc  = 32'h0;
        logic [31:0] hp      = 32'h0;
        logic [31:0] hi      = 32'h0;
        bit          holding = 1'b0;
        int          accepts = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            if (inst_valid) begin
                n_checks++;
                if (pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_stream: got pc=%h inst=%h want pc=%h inst=%h", pc, inst, exp_pc, mem_word(exp_pc));
                end
                if (holding) begin
                    n_checks++;
                    if (pc !== hp || inst !== hi) begin
                        n_fail++; $display("FAIL rnd_stable: got pc=%h inst=%h want %h %h", pc, inst, hp, hi);
                    end
                end
            end
            mem_latency = int'($urandom_range(0, 3));
            inst_ready  = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (inst_valid && inst_ready) begin
                exp_pc = pc + 32'd4;
                accepts++;
            end
            holding = inst_valid && !inst_ready && !redirect;
            hp = pc;
            hi = inst;
        end
        redirect = 1'b0; inst_ready = 1'b0;
        n_checks++;
        if (accepts < 20) begin n_fail++; $display("FAIL rnd_progress: got %0d accepts want >= 20", accepts); end
    endtask

    initial begin
        reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_kill();
        test_redirect_hold();
        test_fault();
        test_reset_in_kill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
